// File: rtl/io_peripherals_pkg.sv
// Shared definitions for the memory-mapped I/O peripheral block:
// register byte offsets inside the 256-byte window, CTRL bit positions,
// the CTRL register layout and the address-to-offset helper.
package io_periph_pkg;

  localparam logic [7:0] OFF_LEDS   = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_SW_CHG = 8'h08;
  localparam logic [7:0] OFF_TIMER  = 8'h0C;
  localparam logic [7:0] OFF_CTRL   = 8'h10;

  localparam int CTRL_TEN   = 0;
  localparam int CTRL_OVF   = 1;
  localparam int CTRL_CHGIE = 2;
  localparam int CTRL_OVFIE = 3;

  // Packed so that ten lands on bit 0, matching the CTRL_* indices above
  typedef struct packed {
    logic ovfie;
    logic chgie;
    logic ovf;
    logic ten;
  } ctrl_t;

  // Word-aligned byte offset within the window; byte-lane bits are ignored
  function automatic logic [7:0] word_offset(input logic [31:0] adr);
    return {adr[7:2], 2'b00};
  endfunction

endpackage

// File: rtl/io_peripherals_if.sv
// Processor data-bus view of the peripheral window: the core drives the
// address/store signals, the peripheral answers with combinational read
// data and a window-hit flag used by top to steer ReadData.
interface io_peripherals_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  modport master (
    output MemWrite, DataAdr, WriteData,
    input  ReadData, hit
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    output ReadData, hit
  );

endinterface

// File: rtl/io_peripherals_switch_debouncer.sv
// Switch debouncer: two-flop synchronizer followed by one stability counter
// shared by the whole vector. The debounced value is accepted once the
// synchronized vector has been unchanged long enough; 'changed' is a
// combinational one-cycle vector of the bits that flip on that acceptance.
module switch_debouncer #(
  parameter int N_IO            = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IO-1:0] raw,
  output logic [N_IO-1:0] debounced,
  output logic [N_IO-1:0] changed
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 2);

  logic [N_IO-1:0] sync_a;
  logic [N_IO-1:0] sync_b;
  logic [N_IO-1:0] sync_prev;
  logic [CW-1:0]   stable_cnt;
  logic            stable;
  logic            load;

  // Accept on the edge where the count steps onto its terminal value, so the
  // new value appears DEBOUNCE_CYCLES edges after the synchronizer output moves
  assign stable  = (sync_b == sync_prev);
  assign load    = stable && (stable_cnt == CNT_LOAD);
  assign changed = load ? (sync_b ^ debounced) : '0;

  // Synchronize the raw switches and keep last cycle's synchronized value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a    <= '0;
      sync_b    <= '0;
      sync_prev <= '0;
    end else begin
      sync_a    <= raw;
      sync_b    <= sync_a;
      sync_prev <= sync_b;
    end
  end

  // Count stable cycles, restarting on any change and saturating at the top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_cnt <= '0;
    end else if (!stable) begin
      stable_cnt <= '0;
    end else if (stable_cnt != CNT_MAX) begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  // Capture the synchronized vector once it has been stable long enough
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debounced <= '0;
    end else if (load) begin
      debounced <= sync_b;
    end
  end

endmodule

// File: rtl/io_peripherals.sv
// Memory-mapped I/O slave: LED register, debounced switches with sticky
// change flags, a prescaled 32-bit timer with overflow, and a level
// interrupt. Reads are combinational so the single-cycle core can use them
// in the same cycle as the access.
module io_peripherals
  import io_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
  parameter int          N_IO            = 10,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          TIMER_DIV       = 50
) (
  input  logic             clk,
  input  logic             reset,
  io_peripherals_if.slave  bus,
  input  logic [N_IO-1:0]  switches,
  output logic [N_IO-1:0]  leds,
  output logic             irq
);

  localparam int            PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  logic [7:0]      offset;
  logic            sel_hit;
  logic            wr;
  logic            wr_leds;
  logic            wr_chg;
  logic            wr_timer;
  logic            wr_ctrl;
  logic [N_IO-1:0] sw;
  logic [N_IO-1:0] sw_changed;
  logic [N_IO-1:0] sw_chg;
  logic [31:0]     timer;
  logic [PW-1:0]   presc;
  logic            tick;
  logic            overflow;
  ctrl_t           ctrl;
  logic [31:0]     rdata;

  switch_debouncer #(
    .N_IO            (N_IO),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .reset     (reset),
    .raw       (switches),
    .debounced (sw),
    .changed   (sw_changed)
  );

  // Decode is forced inactive during reset so hit and ReadData read 0
  assign sel_hit  = !reset && (bus.DataAdr[31:8] == BASE_ADDR[31:8]);
  assign offset   = word_offset(bus.DataAdr);
  assign wr       = bus.MemWrite && sel_hit;
  assign wr_leds  = wr && (offset == OFF_LEDS);
  assign wr_chg   = wr && (offset == OFF_SW_CHG);
  assign wr_timer = wr && (offset == OFF_TIMER);
  assign wr_ctrl  = wr && (offset == OFF_CTRL);

  // A load of TIMER takes precedence over the tick, so it cannot overflow
  assign tick     = ctrl.ten && (presc == PRESC_MAX);
  assign overflow = tick && !wr_timer && (timer == 32'hFFFF_FFFF);

  assign bus.hit      = sel_hit;
  assign bus.ReadData = rdata;
  assign irq          = (ctrl.chgie && (|sw_chg)) || (ctrl.ovfie && ctrl.ovf);

  // Combinational read mux; unmapped offsets and unused upper bits read 0
  always_comb begin
    rdata = '0;
    if (sel_hit) begin
      case (offset)
        OFF_LEDS:   rdata[N_IO-1:0] = leds;
        OFF_SW:     rdata[N_IO-1:0] = sw;
        OFF_SW_CHG: rdata[N_IO-1:0] = sw_chg;
        OFF_TIMER:  rdata           = timer;
        OFF_CTRL:   rdata[3:0]      = ctrl;
        default:    rdata           = '0;
      endcase
    end
  end

  // LED register, loaded by full-word stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds <= '0;
    end else if (wr_leds) begin
      leds <= bus.WriteData[N_IO-1:0];
    end
  end

  // Sticky change flags: write-1-to-clear, with a new change winning
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_chg <= '0;
    end else begin
      sw_chg <= (sw_chg & ~(wr_chg ? bus.WriteData[N_IO-1:0] : '0)) | sw_changed;
    end
  end

  // Prescaler runs only while enabled and holds its value when disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (ctrl.ten) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  // Timer count: a store loads it, otherwise each tick increments it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
    end else if (wr_timer) begin
      timer <= bus.WriteData;
    end else if (tick) begin
      timer <= timer + 32'd1;
    end
  end

  // Control register; OVF is sticky and a simultaneous overflow beats its clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl.ten   <= bus.WriteData[CTRL_TEN];
        ctrl.chgie <= bus.WriteData[CTRL_CHGIE];
        ctrl.ovfie <= bus.WriteData[CTRL_OVFIE];
      end
      ctrl.ovf <= overflow || (ctrl.ovf && !(wr_ctrl && bus.WriteData[CTRL_OVF]));
    end
  end

endmodule

// File: tb/tb_io_peripherals.sv
// Scoreboard bench for io_peripherals with DEBOUNCE_CYCLES=4, TIMER_DIV=3.
// Stimulus drives the bus just after each falling edge and queues expected
// values just after each rising edge; the monitor pops and compares them on
// the following falling edge.
module tb_io_peripherals;

  localparam logic [31:0] BASE     = 32'hFFFF_FF00;
  localparam logic [31:0] A_LEDS   = BASE + 32'h00;
  localparam logic [31:0] A_SW     = BASE + 32'h04;
  localparam logic [31:0] A_SW_CHG = BASE + 32'h08;
  localparam logic [31:0] A_TIMER  = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL   = BASE + 32'h10;

  localparam int K_RD   = 0;
  localparam int K_LEDS = 1;
  localparam int K_HIT  = 2;
  localparam int K_IRQ  = 3;

  logic       clk;
  logic       reset;
  logic [9:0] switches;
  logic [9:0] leds;
  logic       irq;

  io_peripherals_if bus ();

  io_peripherals #(
    .BASE_ADDR       (BASE),
    .N_IO            (10),
    .DEBOUNCE_CYCLES (4),
    .TIMER_DIV       (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];

  int          compared;
  int          mismatched;
  logic [31:0] mon_exp;
  logic [31:0] mon_act;
  int          mon_kind;
  string       mon_name;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the live DUT outputs
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_kind = kind_q.pop_front();
      mon_name = name_q.pop_front();
      case (mon_kind)
        K_RD:    mon_act = bus.ReadData;
        K_LEDS:  mon_act = {22'b0, leds};
        K_HIT:   mon_act = {31'b0, bus.hit};
        default: mon_act = {31'b0, irq};
      endcase
      compared = compared + 1;
      if (mon_act !== mon_exp) begin
        mismatched = mismatched + 1;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", mon_name, mon_act, mon_exp);
      end
    end
  end

  // One clock edge of bus activity, inputs changed away from the edge
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    #1;
    bus.MemWrite  = we;
    bus.DataAdr   = addr;
    bus.WriteData = data;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, A_SW, 32'h0);
  endtask

  // Point the bus at addr and queue the value the monitor must see
  task automatic checkOutput(input int kind, input logic [31:0] addr, input logic [31:0] expected,
                             input string name);
    bus.DataAdr = addr;
    exp_q.push_back(expected);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared      = 0;
    mismatched    = 0;
    reset         = 1'b1;
    switches      = '0;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = A_LEDS;
    bus.WriteData = 32'h0;

    // Reset state
    #1;
    checkOutput(K_HIT,  A_LEDS, 32'h0, "reset_hit");
    checkOutput(K_RD,   A_LEDS, 32'h0, "reset_rdata");
    checkOutput(K_LEDS, A_LEDS, 32'h0, "reset_leds");
    checkOutput(K_IRQ,  A_LEDS, 32'h0, "reset_irq");
    compared = compared + 1;
    if (leds !== 10'h000) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL reset_leds_direct: got 0x%03h, expected 0x000", leds);
    end
    compared = compared + 1;
    if (irq !== 1'b0) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL reset_irq_direct: got %b, expected 0", irq);
    end
    @(negedge clk);
    #1;
    reset = 1'b0;

    // LED write and decode
    applyStimulus(1'b1, A_LEDS, 32'h0000_03A5);
    checkOutput(K_LEDS, A_LEDS, 32'h3A5, "led_write_leds");
    checkOutput(K_RD,   A_LEDS, 32'h3A5, "led_write_read");
    checkOutput(K_HIT,  A_LEDS, 32'h1,   "led_hit");
    applyStimulus(1'b1, 32'h0000_0040, 32'h0000_00FF);
    checkOutput(K_HIT,  32'h0000_0040, 32'h0,   "miss_hit");
    checkOutput(K_LEDS, 32'h0000_0040, 32'h3A5, "miss_leds");
    checkOutput(K_RD,   32'h0000_0040, 32'h0,   "miss_rdata");
    applyStimulus(1'b1, BASE + 32'h20, 32'hFFFF_FFFF);
    checkOutput(K_RD, BASE + 32'h20, 32'h0, "unmapped_read");
    idle();
    checkOutput(K_RD, BASE + 32'h03, 32'h3A5, "byte_bits_ignored");

    // Debounce latency: accepted DEBOUNCE_CYCLES+1 edges after the input moves
    switches = 10'h004;
    repeat (5) idle();
    checkOutput(K_RD, A_SW, 32'h0, "debounce_early");
    idle();
    checkOutput(K_RD, A_SW, 32'h4, "debounce_sw");
    idle();
    checkOutput(K_RD,  A_SW_CHG, 32'h4, "debounce_chg");
    checkOutput(K_IRQ, A_SW_CHG, 32'h0, "chg_irq_masked");

    // A two-cycle bounce must not be accepted
    switches = 10'h005;
    repeat (2) idle();
    switches = 10'h004;
    for (int i = 0; i < 10; i++) begin
      idle();
      checkOutput(K_RD, A_SW, 32'h4, "bounce_sw");
    end
    idle();
    checkOutput(K_RD, A_SW_CHG, 32'h4, "bounce_chg");

    // Write-1-to-clear of change flags
    switches = 10'h005;
    repeat (8) idle();
    checkOutput(K_RD, A_SW_CHG, 32'h5, "chg_accumulate");
    applyStimulus(1'b1, A_SW_CHG, 32'h1);
    checkOutput(K_RD, A_SW_CHG, 32'h4, "w1c_clear");

    // Clear coinciding with a new change on the same bit: set wins
    switches = 10'h004;
    repeat (5) idle();
    checkOutput(K_RD, A_SW_CHG, 32'h4, "collide_before");
    applyStimulus(1'b1, A_SW_CHG, 32'h1);
    checkOutput(K_RD, A_SW_CHG, 32'h5, "collide_set_wins");
    applyStimulus(1'b1, A_CTRL, 32'h4);
    checkOutput(K_RD,  A_CTRL, 32'h4, "ctrl_chgie");
    checkOutput(K_IRQ, A_CTRL, 32'h1, "chg_irq");
    applyStimulus(1'b1, A_SW_CHG, 32'h5);
    checkOutput(K_RD,  A_SW_CHG, 32'h0, "w1c_all");
    checkOutput(K_IRQ, A_SW_CHG, 32'h0, "chg_irq_clear");

    // Timer: first tick TIMER_DIV edges after enable
    applyStimulus(1'b1, A_CTRL, 32'h1);
    repeat (2) idle();
    checkOutput(K_RD, A_TIMER, 32'h0, "timer_pre_tick");
    idle();
    checkOutput(K_RD, A_TIMER, 32'h1, "timer_tick1");
    repeat (3) idle();
    checkOutput(K_RD, A_TIMER, 32'h2, "timer_tick2");

    // Overflow sets OVF, which drives irq once OVFIE is set
    applyStimulus(1'b1, A_TIMER, 32'hFFFF_FFFF);
    idle();
    checkOutput(K_RD, A_TIMER, 32'hFFFF_FFFF, "timer_load");
    idle();
    checkOutput(K_RD,  A_TIMER, 32'h0, "timer_wrap");
    checkOutput(K_IRQ, A_TIMER, 32'h0, "ovf_irq_masked");
    idle();
    checkOutput(K_RD, A_CTRL, 32'h3, "ovf_set");
    applyStimulus(1'b1, A_CTRL, 32'h9);
    checkOutput(K_RD,  A_CTRL, 32'hB, "ovfie_set");
    checkOutput(K_IRQ, A_CTRL, 32'h1, "ovf_irq");
    applyStimulus(1'b1, A_CTRL, 32'hB);
    checkOutput(K_RD,  A_CTRL, 32'h9, "ovf_clear");
    checkOutput(K_IRQ, A_CTRL, 32'h0, "ovf_irq_clear");
    idle();
    checkOutput(K_RD, A_TIMER, 32'h1, "timer_after_clear");

    // TIMER write on a tick edge: the write wins
    idle();
    applyStimulus(1'b1, A_TIMER, 32'h100);
    checkOutput(K_RD, A_TIMER, 32'h100, "timer_write_wins");
    repeat (2) idle();
    checkOutput(K_RD, A_TIMER, 32'h100, "timer_hold");
    idle();
    checkOutput(K_RD, A_TIMER, 32'h101, "timer_resume");

    // OVF clear coinciding with overflow: OVF stays set
    applyStimulus(1'b1, A_TIMER, 32'hFFFF_FFFF);
    idle();
    applyStimulus(1'b1, A_CTRL, 32'hB);
    checkOutput(K_RD,  A_CTRL, 32'hB, "ovf_set_wins");
    checkOutput(K_IRQ, A_CTRL, 32'h1, "ovf_set_wins_irq");
    idle();
    checkOutput(K_RD, A_TIMER, 32'h0, "timer_wrap2");

    // Asynchronous reset in the middle of a debounce and a running timer
    switches = 10'h3FF;
    repeat (3) idle();
    reset = 1'b1;
    #1;
    checkOutput(K_LEDS, A_TIMER, 32'h0, "midreset_leds");
    checkOutput(K_HIT,  A_TIMER, 32'h0, "midreset_hit");
    checkOutput(K_RD,   A_TIMER, 32'h0, "midreset_rdata");
    checkOutput(K_IRQ,  A_TIMER, 32'h0, "midreset_irq");
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle();
    checkOutput(K_RD, A_TIMER, 32'h0, "postreset_timer");
    idle();
    checkOutput(K_RD, A_CTRL, 32'h0, "postreset_ctrl");
    idle();
    checkOutput(K_LEDS, A_SW, 32'h0, "postreset_leds");
    idle();
    checkOutput(K_RD, A_SW, 32'h0, "postreset_sw_early");
    idle();
    checkOutput(K_RD, A_SW, 32'h3FF, "postreset_sw");
    idle();
    checkOutput(K_RD, A_SW_CHG, 32'h3FF, "postreset_chg");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    if (compared < 12) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL check_count: got %0d, expected at least 12", compared);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    if (mismatched == 0) begin
      $display("[TB] PASS");
    end else begin
      $display("[TB] FAIL %0d mismatches", mismatched);
    end
    $finish;
  end

endmodule

// File: doc/io_peripherals.md
# io_peripherals

Memory-mapped I/O slave on the processor data bus, downstream of the core's `DataAdr`/`WriteData`/`MemWrite` outputs and alongside data memory inside `top`. It drives the board LEDs from a writable register and presents debounced board switches with sticky change flags. It also holds a prescaled 32-bit timer. Reads are combinational so the single-cycle core can mux `ReadData` in the same cycle as the access.

## Interface
- `BASE_ADDR`, 32'hFFFF_FF00, word-aligned base of the 256-byte peripheral window
- `N_IO`, 10, number of switches and of LEDs
- `DEBOUNCE_CYCLES`, 50000, cycles a synchronized switch vector must stay stable before it is accepted (≥2)
- `TIMER_DIV`, 50, clock cycles per timer increment (≥1)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `MemWrite`  in  1  store strobe from core
- `DataAdr`  in  32  byte address from core
- `WriteData`  in  32  store data from core
- `ReadData`  out  32  read data for addressed register, combinational
- `hit`  out  1  `DataAdr` lies in the window; `top` uses it to select `ReadData` over data memory
- `switches`  in  N_IO  raw asynchronous board switches
- `leds`  out  N_IO  LED drive, registered
- `irq`  out  1  level interrupt request

## Operation
- Decode: `hit` = `DataAdr[31:8] == BASE_ADDR[31:8]`. Offset = `DataAdr[7:2]`; bits [1:0] are ignored. Only full-word stores are supported. A write happens when `MemWrite & hit`.
- Register map (byte offsets):
  - 0x00 LEDS: RW, bits [N_IO-1:0]
  - 0x04 SW: RO, debounced switches
  - 0x08 SW_CHG: sticky per-bit change flags; write-1-to-clear
  - 0x0C TIMER: RW, 32-bit count; a write loads it
  - 0x10 CTRL: bit0 TEN (timer enable), bit1 OVF (sticky, write-1-to-clear), bit2 CHGIE, bit3 OVFIE
- Unmapped offsets inside the window read 0 and ignore writes. Unused upper bits read 0.
- Switch path:
  - Two-flop synchronizer, then a single stability counter shared by the whole vector.
  - The counter clears whenever the synchronized vector differs from its previous-cycle value.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the vector unchanged, SW loads the synchronized vector.
  - On that load, SW_CHG |= old SW ^ new SW.
- SW_CHG set and clear in the same cycle on the same bit: set wins.
- Timer:
  - The prescaler counts 0..TIMER_DIV-1 only while TEN=1. At terminal count it emits a tick and wraps to 0.
  - Clearing TEN holds the prescaler value.
  - A tick increments TIMER modulo 2^32. Wrap from 0xFFFF_FFFF to 0 sets OVF.
  - TIMER write and tick in the same cycle: the write wins and no increment occurs.
  - CTRL OVF clear and overflow in the same cycle: OVF stays set.
- `irq` = (CHGIE & |SW_CHG) | (OVFIE & OVF), combinational from registers.

## Timing
- Reset (async assert, released synchronously by design use) clears to 0: `leds`, SW, SW_CHG, TIMER, CTRL, prescaler, synchronizer flops, and stability counter.
- `ReadData`, `hit` and `irq` are functions of registers and `DataAdr` only. All three are 0 during reset.
- A store at edge k is visible on `leds` and on readback after edge k.
- Switch latency: the input changes before edge n and stays stable afterward. The synchronized value updates at edge n+1; SW and SW_CHG update at edge n+1+DEBOUNCE_CYCLES.
- Any bounce inside the window restarts the count from the last change.
- The timer increments once per TIMER_DIV enabled cycles. The first tick comes TIMER_DIV edges after TEN is written to 1 from a reset prescaler.
- Reset mid-debounce or mid-prescale discards all partial counts.

## Structure
- Package `io_periph_pkg`: offset localparams (`OFF_LEDS`, `OFF_SW`, `OFF_SW_CHG`, `OFF_TIMER`, `OFF_CTRL`) and CTRL bit indices.
- Sub-module `switch_debouncer`, parameterized N_IO and DEBOUNCE_CYCLES: synchronizer, stability counter, and debounced output with a one-cycle `changed` vector. The top level holds the register file, timer and decode.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and TIMER_DIV=3.
- LED write: store 0x3A5 to 0xFFFF_FF00 → `leds`=0x3A5 after that edge; load returns 0x3A5. Store to 0x0000_0040 → `hit`=0, `leds` unchanged.
- Debounce: `switches`=4 held → SW reads 4 and SW_CHG=0x004 exactly 5 edges later. Toggle bit 0 for 2 cycles then release → SW unchanged.
- W1C: SW_CHG=0x005, write 0x001 → reads 0x004. Write coinciding with a new change on bit 0 → bit 0 remains 1.
- Timer: CTRL=1 → TIMER=1 after 3 edges, 2 after 6. Write TIMER=0xFFFF_FFFF, next tick → 0, OVF=1. With OVFIE=1 → `irq`=1. Write CTRL=0xB (TEN|OVF|OVFIE) → OVF=0, `irq`=0.
- Collision: TIMER write of 0x100 on a tick edge → reads 0x100, not 0x101.
- Reset mid-operation: assert `reset` asynchronously while the timer runs and a debounce is pending → all outputs 0 immediately; SW stays 0 until a fresh full debounce.
